isqrt_req_arbiter: RTL and testbench
====================================

// Module: isqrt_req_arbiter
// PURPOSE
// - Shares one fixed-latency InvertSQRoot pipeline between NREQ requesters.
// - Round-robin selects one request per cycle, drives the pipeline ce/DataIn,
//   tags each issue with its requester id, and routes each DataValid result
//   back to the owner.
// - Sits between the client blocks and InvertSQRoot. Owns all pipeline sequencing.
// PARAMETERS
// - NREQ    4   number of requesters (2..8)
// - IDW     2   requester id width, clog2(NREQ)
// - LATENCY 8   cycles from sq_ce high to the matching sq_valid high (>=1)
// PORTS
// - clk        in   1        clock, rising edge
// - rst        in   1        reset, asynchronous, active-low
// - arb_en     in   1        1 = issue allowed; 0 = no new grants, in-flight results still drain
// - req_valid  in   NREQ     request pending, per requester
// - req_data   in   NREQ*32  IEEE-754 single-precision operand; requester i uses bits [32i+31:32i]
// - req_ready  out  NREQ     one-hot grant; request i accepted in a cycle where req_valid[i] & req_ready[i]
// - sq_ce      out  1        registered issue strobe to InvertSQRoot ce
// - sq_din     out  32       registered operand to InvertSQRoot DataIn
// - sq_valid   in   1        InvertSQRoot DataValid
// - sq_dout    in   32       InvertSQRoot DataOut
// - resp_valid out  NREQ     one-hot result strobe, 1 cycle, no backpressure
// - resp_data  out  32       result, valid with resp_valid
// - resp_id    out  IDW      id of the current result owner
// - inflight   out  IDW+4    number of issued, not yet returned operations
// - busy       out  1        inflight != 0 or sq_ce
// BEHAVIOUR
// - Reset (rst=0, async): outputs are req_ready=0, sq_ce=0, sq_din=0, resp_valid=0,
//   resp_data=0, resp_id=0, inflight=0, busy=0.
// - Reset also clears the tag pipe and sets the round-robin pointer to 0.
// - Reset mid-operation discards all in-flight tags. sq_valid pulses arriving afterwards
//   with no tag are ignored.
// - Grant is combinational:
//   - req_ready = one-hot of the first req_valid[i] at or after ptr, cyclic.
//   - Gated by arb_en. At most one bit is set.
// - Pointer advances on accept only: ptr <= granted id + 1, wrapping NREQ-1 -> 0.
// - Issue: an accept in cycle t gives sq_ce=1 and sq_din=req_data[id] in cycle t+1.
//   With no accept, sq_ce=0 and sq_din holds its value.
// - Tag pipe: LATENCY-deep shift register of {valid,id}.
//   - Loaded with {sq_ce, issued id}.
//   - Its output aligns with sq_valid.
// - Response: when the tag pipe output is valid, the next cycle has:
//   - resp_valid[id]=1
//   - resp_data = sq_dout
//   - resp_id = id
//   - Accept-to-response latency is LATENCY+2 cycles.
// - inflight changes by +1 on sq_ce and -1 on tag-pipe-output valid. It is unchanged when both
//   happen in the same cycle. It never exceeds LATENCY, so no overflow is possible.
// - Throughput: one op per cycle sustained. A requester holding req_valid is granted at
//   least once every NREQ accepts (no starvation).
// - Dropping arb_en mid-stream: requests already accepted still issue and return;
//   req_ready drops the same cycle.
// - Results return in issue order. Results are never lost or duplicated.
// CONFIGURATION
// - Macro ISQRT_ARB_TAG_CHECK_EN, defined:
//   - Adds output tag_err (1 bit, reset 0, sticky until rst).
//   - tag_err is set when sq_valid differs from the tag-pipe output valid bit in any cycle.
//   - Response routing is unchanged.
// - Macro undefined: no tag_err port and no compare logic. sq_valid is ignored;
//   the tag pipe alone drives responses.
// TESTING
// - Bench replaces InvertSQRoot with a LATENCY=8 stub: DataOut = DataIn ^ 32'hFFFF_0000,
//   DataValid = delayed ce.
// 1 Single op: req_valid=4'b0100, req_data[2]=32'h4080_0000 at t0 -> sq_ce and
//   sq_din=32'h4080_0000 at t0+1; resp_valid=4'b0100, resp_data=32'hBF7F_0000, resp_id=2 at t0+10.
// 2 All 4 requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3;
//   responses in the same order; inflight peaks at 8.
// 3 Fairness: req 0 always valid, req 3 raised at cycle 5 -> req 3 is granted within 4 cycles;
//   the ptr wrap 3->0 is checked.
// 4 arb_en=0 with 2 ops in flight -> no new grants; both responses arrive;
//   inflight=0 and busy=0 after the last one.
// 5 rst asserted at cycle 4 of a 6-op burst -> every output reads 0 immediately.
//   Stray stub sq_valid pulses afterwards produce no resp_valid.
// 6 With ISQRT_ARB_TAG_CHECK_EN: stub injects an extra sq_valid -> tag_err=1 the next cycle
//   and stays 1; without the macro, responses are unaffected.

Source files
------------

// File: rtl/isqrt_req_arbiter.sv
// isqrt_req_arbiter
// Round-robin front end that shares one fixed-latency InvertSQRoot pipeline
// between NREQ requesters. It makes one grant per cycle and registers the
// issue (sq_ce/sq_din). Each issue is tagged with the requester id, and each
// returning result is routed back to the requester that issued it.
// Optional feature: define ISQRT_ARB_TAG_CHECK_EN to add the sticky tag_err
// output. tag_err flags any cycle where sq_valid disagrees with the tag pipe.
module isqrt_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int LATENCY = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               sq_ce,
    output logic [31:0]        sq_din,
    input  logic               sq_valid,
    input  logic [31:0]        sq_dout,
    output logic [NREQ-1:0]    resp_valid,
    output logic [31:0]        resp_data,
    output logic [IDW-1:0]     resp_id,
    output logic [IDW+3:0]     inflight,
`ifdef ISQRT_ARB_TAG_CHECK_EN
    output logic               tag_err,
`endif
    output logic               busy
);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;
    logic            grant_found;
    logic            accept;

    logic            sq_ce_q, sq_ce_d;
    logic [31:0]     sq_din_q, sq_din_d;
    logic [IDW-1:0]  issue_id_q, issue_id_d;

    tag_t            tag_pipe_q [LATENCY];
    tag_t            tag_pipe_d [LATENCY];
    tag_t            tag_out;

    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [IDW+3:0]  inflight_q, inflight_d;

    assign tag_out = tag_pipe_q[LATENCY-1];

    // Cyclic search for the first pending request at or after the pointer.
    // The grant is gated by arb_en and by reset.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        req_ready = (grant_found && arb_en && rst) ? (NREQ'(1) << grant_id) : '0;
    end

    assign accept = |req_ready;

    // Issue stage: pointer advance, registered strobe/operand, and the id of the issue.
    always_comb begin
        ptr_d      = ptr_q;
        sq_ce_d    = accept;
        sq_din_d   = sq_din_q;
        issue_id_d = issue_id_q;
        if (accept) begin
            ptr_d      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            sq_din_d   = req_data[32*grant_id +: 32];
            issue_id_d = grant_id;
        end
    end

    // Tag pipe shifts {issue strobe, id}, so its output lines up with sq_valid.
    always_comb begin
        tag_pipe_d    = tag_pipe_q;
        tag_pipe_d[0] = tag_t'{vld: sq_ce_q, id: issue_id_q};
        for (int s = 1; s < LATENCY; s++) begin
            tag_pipe_d[s] = tag_pipe_q[s-1];
        end
    end

    // Response routing from the tag pipe output, plus the in-flight count.
    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        if (tag_out.vld) begin
            resp_valid_d = NREQ'(1) << tag_out.id;
            resp_data_d  = sq_dout;
            resp_id_d    = tag_out.id;
        end
        case ({sq_ce_q, tag_out.vld})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers. Reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            sq_ce_q      <= 1'b0;
            sq_din_q     <= '0;
            issue_id_q   <= '0;
            // NOTE: the tag pipe is reset (unlike a data RAM) because stale valid bits would emit phantom responses.
            tag_pipe_q   <= '{default: '0};
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            inflight_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the shift order does not matter.
            ptr_q        <= ptr_d;
            sq_ce_q      <= sq_ce_d;
            sq_din_q     <= sq_din_d;
            issue_id_q   <= issue_id_d;
            tag_pipe_q   <= tag_pipe_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            inflight_q   <= inflight_d;
        end
    end

`ifdef ISQRT_ARB_TAG_CHECK_EN
    logic tag_err_q, tag_err_d;

    // Sticky flag: the pipeline's valid strobe disagreed with our tag bookkeeping.
    always_comb begin
        tag_err_d = tag_err_q | (sq_valid != tag_out.vld);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_err_q <= 1'b0;
        end else begin
            tag_err_q <= tag_err_d;
        end
    end

    assign tag_err = tag_err_q;
`else
    // Responses are driven by the tag pipe alone, so the pipeline strobe is not needed.
    logic unused_sq_valid;
    assign unused_sq_valid = sq_valid;
`endif

    assign sq_ce      = sq_ce_q;
    assign sq_din     = sq_din_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign inflight   = inflight_q;
    assign busy       = (inflight_q != '0) | sq_ce_q;

endmodule

// File: tb/tb_isqrt_req_arbiter.sv
// Bench for isqrt_req_arbiter with a LATENCY=8 InvertSQRoot stub
// (DataOut = DataIn ^ 32'hFFFF_0000, DataValid = ce delayed by 8 cycles).
// Build with ISQRT_ARB_TAG_CHECK_EN to exercise the tag_err output.
module tb_isqrt_req_arbiter;

    logic         clk;
    logic         rst;
    logic         arb_en;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         sq_ce;
    logic [31:0]  sq_din;
    logic         sq_valid;
    logic [31:0]  sq_dout;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_data;
    logic [1:0]   resp_id;
    logic [5:0]   inflight;
    logic         busy;
`ifdef ISQRT_ARB_TAG_CHECK_EN
    logic         tag_err;
`endif

    int total = 0;
    int bad   = 0;

    isqrt_req_arbiter #(.NREQ(4), .IDW(2), .LATENCY(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sq_ce      (sq_ce),
        .sq_din     (sq_din),
        .sq_valid   (sq_valid),
        .sq_dout    (sq_dout),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .inflight   (inflight),
`ifdef ISQRT_ARB_TAG_CHECK_EN
        .tag_err    (tag_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // InvertSQRoot stub: not reset by rst, so tags discarded by a reset still return as stray pulses.
    logic [7:0]  stub_v_sr;
    logic [31:0] stub_d_sr [8];
    logic        inject;

    always @(posedge clk) begin
        stub_v_sr    <= {stub_v_sr[6:0], sq_ce};
        stub_d_sr[0] <= sq_din ^ 32'hFFFF_0000;
        for (int s = 1; s < 8; s++) stub_d_sr[s] <= stub_d_sr[s-1];
    end

    assign sq_valid = stub_v_sr[7] | inject;
    assign sq_dout  = stub_d_sr[7];

    // Response recorder, sampled on the falling edge.
    typedef struct {
        logic [3:0]  rv;
        logic [1:0]  id;
        logic [31:0] d;
    } resp_t;

    resp_t mon_q[$];
    int    infl_max;

    always @(negedge clk) begin
        if (resp_valid !== 4'b0000) mon_q.push_back('{rv: resp_valid, id: resp_id, d: resp_data});
        if (int'(inflight) > infl_max) infl_max <= int'(inflight);
    end

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        arb_en    = 1'b1;
        inject    = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mon_q.delete();
        infl_max = 0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        total++; if (sq_ce !== 1'b0) begin bad++; $display("FAIL rst_sq_ce: got %b want 0", sq_ce); end
        total++; if (sq_din !== 32'h0) begin bad++; $display("FAIL rst_sq_din: got %h want 0", sq_din); end
        total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
        total++; if (inflight !== 6'd0) begin bad++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
`ifdef ISQRT_ARB_TAG_CHECK_EN
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL rst_tag_err: got %b want 0", tag_err); end
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_release_ready: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req_data          = '0;
        req_data[64 +: 32] = 32'h4080_0000;
        req_data[0 +: 32]  = 32'h1111_1111;
        req_valid         = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++; if (sq_ce !== 1'b1) begin bad++; $display("FAIL single_sq_ce: got %b want 1", sq_ce); end
        total++; if (sq_din !== 32'h4080_0000) begin bad++; $display("FAIL single_sq_din: got %h want 40800000", sq_din); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            #1;
            if (k == 5) begin
                total++; if (inflight !== 6'd1) begin bad++; $display("FAIL single_inflight: got %0d want 1", inflight); end
            end
            if (k < 10) begin
                total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL single_early_resp[%0d]: got %b want 0000", k, resp_valid); end
            end
        end
        total++; if (resp_valid !== 4'b0100) begin bad++; $display("FAIL single_resp_valid: got %b want 0100", resp_valid); end
        total++; if (resp_data !== 32'hBF7F_0000) begin bad++; $display("FAIL single_resp_data: got %h want bf7f0000", resp_data); end
        total++; if (resp_id !== 2'd2) begin bad++; $display("FAIL single_resp_id: got %0d want 2", resp_id); end
        total++; if (inflight !== 6'd0) begin bad++; $display("FAIL single_inflight_end: got %0d want 0", inflight); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
        @(negedge clk);
        #1;
        total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL single_resp_pulse: got %b want 0000", resp_valid); end
    endtask

    task automatic test_all4();
        int          exp_id [8];
        logic [31:0] exp_d  [8];
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h4000_0000 + (c << 8) + i;
            exp_id[c] = c % 4;
            exp_d[c]  = (32'h4000_0000 + (c << 8) + (c % 4)) ^ 32'hFFFF_0000;
            #1;
            total++; if (req_ready !== (4'b0001 << (c % 4))) begin bad++; $display("FAIL all4_ready[%0d]: got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
        end
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 30 && mon_q.size() < 8; i++) @(negedge clk);
        #1;
        total++; if (mon_q.size() != 8) begin bad++; $display("FAIL all4_count: got %0d want 8", mon_q.size()); end
        for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k].rv !== (4'b0001 << exp_id[k]) || mon_q[k].id !== 2'(exp_id[k]) || mon_q[k].d !== exp_d[k]) begin
                bad++;
                $display("FAIL all4_resp[%0d]: got rv=%b id=%0d d=%h want id=%0d d=%h", k, mon_q[k].rv, mon_q[k].id, mon_q[k].d, exp_id[k], exp_d[k]);
            end
        end
        total++; if (infl_max != 8) begin bad++; $display("FAIL all4_inflight_peak: got %0d want 8", infl_max); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = (c >= 5) ? 4'b1001 : 4'b0001;
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h3000_0000 + (c << 8) + i;
            #1;
            total++; if (req_ready !== exp_rdy[c]) begin bad++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, exp_rdy[c]); end
        end
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 30 && mon_q.size() < 8; i++) @(negedge clk);
        #1;
        total++; if (mon_q.size() != 8) begin bad++; $display("FAIL fair_count: got %0d want 8", mon_q.size()); end
        for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
            logic [1:0]  wid;
            logic [31:0] wd;
            wid = (exp_rdy[k] == 4'b1000) ? 2'd3 : 2'd0;
            wd  = (32'h3000_0000 + (k << 8) + int'(wid)) ^ 32'hFFFF_0000;
            total++;
            if (mon_q[k].id !== wid || mon_q[k].d !== wd || mon_q[k].rv !== exp_rdy[k]) begin
                bad++;
                $display("FAIL fair_resp[%0d]: got id=%0d d=%h want id=%0d d=%h", k, mon_q[k].id, mon_q[k].d, wid, wd);
            end
        end
    endtask

    task automatic test_arb_en();
        do_reset();
        @(negedge clk);
        req_data  = {32'hA300_0000, 32'hA200_0000, 32'hA100_0000, 32'hA000_0000};
        req_valid = 4'b0110;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL en_ready0: got %b want 0010", req_ready); end
        @(negedge clk);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL en_ready1: got %b want 0100", req_ready); end
        @(negedge clk);
        arb_en    = 1'b0;
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL en_ready_off: got %b want 0000", req_ready); end
        @(negedge clk);
        #1;
        total++; if (sq_ce !== 1'b0) begin bad++; $display("FAIL en_no_issue: got %b want 0", sq_ce); end
        total++; if (inflight !== 6'd2) begin bad++; $display("FAIL en_inflight2: got %0d want 2", inflight); end
        for (int i = 0; i < 20 && mon_q.size() < 2; i++) @(negedge clk);
        #1;
        total++; if (mon_q.size() != 2) begin bad++; $display("FAIL en_count: got %0d want 2", mon_q.size()); end
        if (mon_q.size() == 2) begin
            total++; if (mon_q[0].id !== 2'd1 || mon_q[0].d !== 32'h5EFF_0000) begin bad++; $display("FAIL en_resp0: got id=%0d d=%h want id=1 d=5eff0000", mon_q[0].id, mon_q[0].d); end
            total++; if (mon_q[1].id !== 2'd2 || mon_q[1].d !== 32'h5DFF_0000) begin bad++; $display("FAIL en_resp1: got id=%0d d=%h want id=2 d=5dff0000", mon_q[1].id, mon_q[1].d); end
        end
        total++; if (inflight !== 6'd0) begin bad++; $display("FAIL en_inflight_end: got %0d want 0", inflight); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy_end: got %b want 0", busy); end
        req_valid = '0;
        arb_en    = 1'b1;
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        int stub_pulses = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h5000_0000 + (c << 8) + i;
        end
        @(negedge clk);
        #1;
        total++; if (sq_din !== 32'h5000_0303) begin bad++; $display("FAIL rmid_sq_din_before: got %h want 50000303", sq_din); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_ready: got %b want 0000", req_ready); end
        total++; if (sq_ce !== 1'b0) begin bad++; $display("FAIL rmid_sq_ce: got %b want 0", sq_ce); end
        total++; if (sq_din !== 32'h0) begin bad++; $display("FAIL rmid_sq_din: got %h want 0", sq_din); end
        total++; if (resp_valid !== 4'b0000 || resp_data !== 32'h0 || resp_id !== 2'd0) begin bad++; $display("FAIL rmid_resp: got %b/%h/%0d want 0/0/0", resp_valid, resp_data, resp_id); end
        total++; if (inflight !== 6'd0) begin bad++; $display("FAIL rmid_inflight: got %0d want 0", inflight); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (resp_valid !== 4'b0000) stray++;
            if (sq_valid === 1'b1) stub_pulses++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rmid_stray_resp: got %0d want 0", stray); end
        total++; if (stub_pulses == 0) begin bad++; $display("FAIL rmid_stub_pulses: got 0 want nonzero"); end
    endtask

    task automatic test_tag();
        do_reset();
        @(negedge clk);
        req_data[0 +: 32] = 32'h3F80_0000;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
`ifdef ISQRT_ARB_TAG_CHECK_EN
        #1;
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL tag_err_pre: got %b want 0", tag_err); end
`endif
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL tag_inject_resp: got %b want 0000", resp_valid); end
`ifdef ISQRT_ARB_TAG_CHECK_EN
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL tag_err_set: got %b want 1", tag_err); end
`endif
        for (int i = 0; i < 20 && mon_q.size() < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        total++; if (mon_q.size() != 1) begin bad++; $display("FAIL tag_count: got %0d want 1", mon_q.size()); end
        if (mon_q.size() >= 1) begin
            total++; if (mon_q[0].rv !== 4'b0001 || mon_q[0].d !== 32'hC07F_0000) begin bad++; $display("FAIL tag_resp: got rv=%b d=%h want rv=0001 d=c07f0000", mon_q[0].rv, mon_q[0].d); end
        end
`ifdef ISQRT_ARB_TAG_CHECK_EN
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL tag_err_sticky: got %b want 1", tag_err); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        arb_en    = 1'b1;
        req_valid = 4'b1111;
        req_data  = '0;
        inject    = 1'b0;
        stub_v_sr = '0;
        for (int s = 0; s < 8; s++) stub_d_sr[s] = '0;
        infl_max  = 0;
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_arb_en();
        test_reset_mid();
        test_tag();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
